// File: rtl/ring_osc_freq_meter_if.sv
// Host-side bundle of the ring-oscillator frequency meter: start request,
// status flags and the measured edge count.
interface ring_osc_freq_meter_if #(
   parameter int COUNT_BITS = 12
);
   logic                  start;
   logic                  busy;
   logic                  valid;
   logic [COUNT_BITS-1:0] count;
   logic                  overflow;

   modport master (
      output start,
      input  busy,
      input  valid,
      input  count,
      input  overflow
   );

   modport slave (
      input  start,
      output busy,
      output valid,
      output count,
      output overflow
   );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// Counts synchronized rising edges of a ring-oscillator output over a fixed
// window of system clocks, after enabling the oscillator and letting it settle.
module ring_osc_freq_meter #(
   parameter int GATE_BITS     = 10,
   parameter int COUNT_BITS    = 12,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  osc_in,
   output logic                  osc_en,
   ring_osc_freq_meter_if.slave  bus
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_e;

   state_e                 state_q, state_d;
   logic                   startReq_q, startReq_d;
   logic [SW-1:0]          settleCnt_q, settleCnt_d;
   logic [GATE_BITS-1:0]   gateCnt_q, gateCnt_d;
   logic [COUNT_BITS-1:0]  count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   sync1_q, sync2_q, sync3_q;
   logic                   rise;
   logic                   busyInt;
   logic                   accept;

   // osc_in is only ever sampled as data; sync3 is the history flop for edge detection
   assign rise    = sync2_q & ~sync3_q;
   assign busyInt = startReq_q | (state_q == SETTLE) | (state_q == COUNT);
   assign accept  = bus.start & ~busyInt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         startReq_q  <= 1'b0;
         settleCnt_q <= '0;
         gateCnt_q   <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         startReq_q  <= startReq_d;
         settleCnt_q <= settleCnt_d;
         gateCnt_q   <= gateCnt_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         sync1_q     <= osc_in;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      startReq_d  = 1'b0;
      settleCnt_d = settleCnt_q;
      gateCnt_d   = gateCnt_q;
      count_d     = count_q;
      overflow_d  = overflow_q;

      case (state_q)
         IDLE: begin
            if (startReq_q) begin
               state_d     = (SETTLE_CYCLES == 0) ? COUNT : SETTLE;
               settleCnt_d = '0;
               gateCnt_d   = '0;
            end
         end
         SETTLE: begin
            if (settleCnt_q == SETTLE_LAST) begin
               state_d   = COUNT;
               gateCnt_d = '0;
            end else begin
               settleCnt_d = settleCnt_q + 1'b1;
            end
         end
         COUNT: begin
            if (rise) begin
               if (count_q == '1) begin
                  overflow_d = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
            if (gateCnt_q == '1) begin
               state_d = DONE;
            end else begin
               gateCnt_d = gateCnt_q + 1'b1;
            end
         end
         default: ;
      endcase

      // An accepted start spends one launch cycle in IDLE so the old result drops at once
      if (accept) begin
         state_d    = IDLE;
         startReq_d = 1'b1;
         count_d    = '0;
         overflow_d = 1'b0;
      end
   end

   assign osc_en       = busyInt;
   assign bus.busy     = busyInt;
   assign bus.valid    = (state_q == DONE);
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench for ring_osc_freq_meter: expected results are queued when a
// measurement is launched and compared when valid rises.
module tb_ring_osc_freq_meter;

   logic clk = 1'b0;
   logic rst_n;
   logic oscRawA = 1'b0;
   logic oscRawB = 1'b0;
   logic stuckA = 1'b0;
   logic oscEnA, oscEnB;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   startEdge = 0;

   typedef struct {
      logic [11:0] count;
      logic        ovf;
   } exp_t;

   exp_t sbQ[$];

   ring_osc_freq_meter_if #(.COUNT_BITS(12)) ifA ();
   ring_osc_freq_meter_if #(.COUNT_BITS(8))  ifB ();

   ring_osc_freq_meter #(.GATE_BITS(10), .COUNT_BITS(12), .SETTLE_CYCLES(16)) dutA (
      .clk    (clk),
      .rst_n  (rst_n),
      .osc_in (oscRawA & ~stuckA),
      .osc_en (oscEnA),
      .bus    (ifA)
   );

   ring_osc_freq_meter #(.GATE_BITS(10), .COUNT_BITS(8), .SETTLE_CYCLES(16)) dutB (
      .clk    (clk),
      .rst_n  (rst_n),
      .osc_in (oscRawB),
      .osc_en (oscEnB),
      .bus    (ifB)
   );

   // 10 ns system clock; oscillators are offset by 3 ns so they never toggle on a clock edge
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3;
      forever #40 oscRawA = ~oscRawA;
   end

   initial begin
      #3;
      forever #10 oscRawB = ~oscRawB;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic driveStart(input bit selB, input logic v);
      if (selB) ifB.start = v;
      else      ifA.start = v;
   endtask

   task automatic sampleOut(input bit selB, output logic en, output logic busy, output logic valid,
                            output logic ovf, output logic [11:0] count);
      if (selB) begin
         en = oscEnB; busy = ifB.busy; valid = ifB.valid; ovf = ifB.overflow; count = {4'b0, ifB.count};
      end else begin
         en = oscEnA; busy = ifA.busy; valid = ifA.valid; ovf = ifA.overflow; count = ifA.count;
      end
   endtask

   task automatic checkAllZero(input bit selB, input string tag);
      logic en, b, v, o;
      logic [11:0] c;
      sampleOut(selB, en, b, v, o, c);
      checkOutput({tag, "_osc_en"}, 32'(en), 0);
      checkOutput({tag, "_busy"}, 32'(b), 0);
      checkOutput({tag, "_valid"}, 32'(v), 0);
      checkOutput({tag, "_count"}, 32'(c), 0);
      checkOutput({tag, "_overflow"}, 32'(o), 0);
   endtask

   task automatic pulseStart(input bit selB);
      @(negedge clk);
      driveStart(selB, 1'b1);
      @(posedge clk);
      #1;
      driveStart(selB, 1'b0);
   endtask

   task automatic applyStimulus(input bit selB, input logic [11:0] expCount, input logic expOvf);
      exp_t e;
      pulseStart(selB);
      startEdge = cyc;
      e.count = expCount;
      e.ovf   = expOvf;
      sbQ.push_back(e);
   endtask

   task automatic waitResult(input bit selB, input string tag);
      logic en, b, v, o;
      logic [11:0] c;
      exp_t e;
      sampleOut(selB, en, b, v, o, c);
      while (!v && (cyc - startEdge) < 1200) begin
         @(posedge clk);
         #1;
         sampleOut(selB, en, b, v, o, c);
      end
      checkOutput({tag, "_latency"}, 32'(cyc - startEdge), 1041);
      checkOutput({tag, "_valid"}, 32'(v), 1);
      checkOutput({tag, "_osc_en"}, 32'(en), 0);
      checkOutput({tag, "_busy"}, 32'(b), 0);
      checkOutput({tag, "_sb_pending"}, 32'(sbQ.size()), 1);
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checkOutput({tag, "_count"}, 32'(c), 32'(e.count));
         checkOutput({tag, "_overflow"}, 32'(o), 32'(e.ovf));
      end
   endtask

   initial begin
      logic en, b, v, o;
      logic [11:0] c;

      // reset held with start asserted on both meters
      rst_n = 1'b0;
      ifA.start = 1'b1;
      ifB.start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero(1'b0, "resetA");
      checkAllZero(1'b1, "resetB");
      @(negedge clk);
      rst_n = 1'b1;
      ifA.start = 1'b0;
      ifB.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkAllZero(1'b0, "idleA");

      $display("[TB] nominal period-8 measurement");
      applyStimulus(1'b0, 12'd128, 1'b0);
      sampleOut(1'b0, en, b, v, o, c);
      checkOutput("launch_osc_en", 32'(en), 1);
      checkOutput("launch_busy", 32'(b), 1);
      waitResult(1'b0, "nominal");

      $display("[TB] stuck oscillator, started from DONE");
      stuckA = 1'b1;
      repeat (4) @(posedge clk);
      applyStimulus(1'b0, 12'd0, 1'b0);
      sampleOut(1'b0, en, b, v, o, c);
      checkOutput("done_restart_valid_drop", 32'(v), 0);
      checkOutput("done_restart_count_clr", 32'(c), 0);
      waitResult(1'b0, "stuck");
      stuckA = 1'b0;

      $display("[TB] start pulses while busy are ignored");
      repeat (3) @(posedge clk);
      applyStimulus(1'b0, 12'd128, 1'b0);
      repeat (6) @(posedge clk);
      pulseStart(1'b0);
      sampleOut(1'b0, en, b, v, o, c);
      checkOutput("guard_settle_busy", 32'(b), 1);
      while ((cyc - startEdge) < 500) begin
         @(posedge clk);
         #1;
      end
      pulseStart(1'b0);
      sampleOut(1'b0, en, b, v, o, c);
      checkOutput("guard_count_valid", 32'(v), 0);
      waitResult(1'b0, "guard");

      $display("[TB] immediate restart from DONE");
      applyStimulus(1'b0, 12'd128, 1'b0);
      sampleOut(1'b0, en, b, v, o, c);
      checkOutput("restart_valid_drop", 32'(v), 0);
      waitResult(1'b0, "restart");

      $display("[TB] reset in the middle of the gate window");
      pulseStart(1'b0);
      startEdge = cyc;
      while ((cyc - startEdge) < 517) begin
         @(posedge clk);
         #1;
      end
      sampleOut(1'b0, en, b, v, o, c);
      checkOutput("midcount_nonzero", 32'(c != 12'd0), 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkAllZero(1'b0, "midreset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      applyStimulus(1'b0, 12'd128, 1'b0);
      waitResult(1'b0, "after_reset");

      $display("[TB] 8-bit meter saturation with period-2 input");
      applyStimulus(1'b1, 12'd255, 1'b1);
      waitResult(1'b1, "saturate");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
- Measures the frequency of a free-running ring-oscillator output against the system clock.
- Enables the oscillator, lets it settle, then counts synchronized rising edges of osc_in over a fixed gate window of system clocks.
- Presents a saturating count with valid/overflow flags.
- Sits between the ring oscillator (osc_in fed from its divided clock, osc_en driving its enable) and the host register/IO logic.

Parameters:
- GATE_BITS, 10, gate window length is 2^GATE_BITS system clock cycles
- COUNT_BITS, 12, width of the edge-count result
- SETTLE_CYCLES, 16, cycles between oscillator enable and start of the gate window (0 allowed)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  single-cycle request to begin a measurement
- osc_in  input  1  oscillator clock, asynchronous to clk
- osc_en  output  1  oscillator enable, high while measuring
- busy  output  1  high in SETTLE and COUNT
- valid  output  1  count holds a completed result
- count  output  COUNT_BITS  rising edges counted in the last gate window
- overflow  output  1  count saturated during the last window

Behaviour:
- Clocking and reset: single clock domain clk. rst_n is synchronous, active low, sampled on the rising edge of clk.
- Reset values: state=IDLE, osc_en=0, busy=0, valid=0, count=0, overflow=0. Synchronizer flops and internal counters are cleared.
- osc_in path: two-flop synchronizer followed by one history flop. rise = sync2 & ~sync3 (one-cycle pulse per osc_in rising edge). osc_in period must be ≥ 2 clk cycles for exact counting.
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE/DONE + start=1: next cycle enter SETTLE (or COUNT if SETTLE_CYCLES=0). On entry: osc_en=1, busy=1, valid=0, count=0, overflow=0, phase counter=0.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. rise pulses are ignored; the synchronizer flushes during this phase. Then enter COUNT.
- COUNT: lasts exactly 2^GATE_BITS cycles, tracked by a GATE_BITS-wide counter.
  - Each cycle with rise=1 increments count.
  - At all-ones, count holds and overflow sets to 1.
  - A rise in the final COUNT cycle is counted.
- Exit COUNT -> DONE: valid=1, busy=0, osc_en=0. count and overflow are held until the next accepted start or reset.
- Latency: start sampled at edge 0 -> valid high after edge 1+SETTLE_CYCLES+2^GATE_BITS (default 1041).
- start while busy=1: ignored, with no effect on the counters.
- start in DONE: restarts the measurement; valid drops the next cycle.
- rst_n low in any state (including mid-COUNT): all outputs return to reset values at that edge. No partial result is retained.
- start and rst_n low in the same cycle: reset wins.
- osc_in is never used as a clock inside this block.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> osc_en=0, busy=0, valid=0, count=0, overflow=0, state=IDLE.
- Nominal: osc_in square wave, period 8 clk (asynchronous phase offset), pulse start -> osc_en=1 next cycle, valid rises exactly 1041 edges after start, count=128, overflow=0, osc_en=0.
- Stuck oscillator: osc_in held 0, pulse start -> valid after 1041 cycles, count=0, overflow=0.
- Saturation: COUNT_BITS=8, osc_in period 2 clk (512 edges) -> count=255, overflow=1, valid=1.
- Busy guard/restart:
  - start pulsed mid-SETTLE and mid-COUNT -> ignored, valid still at edge 1041.
  - start pulsed in DONE -> valid=0 next cycle, new result after a further 1041 edges.
- Mid-measurement reset: rst_n=0 for 1 cycle at COUNT cycle 500 -> all outputs 0 at that edge. A subsequent start (period-8 input) gives count=128.
